// File: rtl/gx_std_x4_rst_pkg.sv
// Shared types and default timing for the GX standard-PCS x4 reset sequencer.
// Consumed by gx_std_x4_rst_ctrl and gx_std_x4_rst_rx_ch.
package gx_std_x4_rst_pkg;

   localparam int DEF_NUM_CH      = 4;
   localparam int DEF_T_PLLPD_CYC = 8;
   localparam int DEF_T_ANA_CYC   = 8;
   localparam int DEF_T_LTD_CYC   = 1250;
   localparam int DEF_T_DIG_CYC   = 8;

   typedef enum logic [2:0] {
      TX_PD,
      TX_ANA,
      TX_LOCK,
      TX_DIG,
      TX_READY
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_ANA,
      RX_LTD,
      RX_READY
   } rx_state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/gx_std_x4_rst_rx_ch.sv
// One RX reset sequencer channel: synchronisers, ANA/LTD counter and FSM.
// GX_RST_RX_AUTORECOVER_EN: lockedtodata loss in RX_READY restarts the channel.
module gx_std_x4_rst_rx_ch
   import gx_std_x4_rst_pkg::*;
#(
   parameter int T_ANA_CYC = DEF_T_ANA_CYC,
   parameter int T_LTD_CYC = DEF_T_LTD_CYC
)(
   input  logic mgmt_clk,
   input  logic mgmt_reset,
   input  logic rx_reset_req,
   input  logic rx_cal_busy,
   input  logic rx_is_lockedtodata,
   output logic rx_analogreset,
   output logic rx_digitalreset,
   output logic rx_ready
);

   localparam int CNT_MAX = max_int(T_ANA_CYC, T_LTD_CYC);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] ANA_LAST = CNT_W'(T_ANA_CYC - 1);
   localparam logic [CNT_W-1:0] LTD_LAST = CNT_W'(T_LTD_CYC - 1);

   rx_state_t        state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [1:0]       busy_sync_reg, ltd_sync_reg;
   logic             ana_rst_reg, dig_rst_reg, ready_reg;
   logic             busy_sync, ltd_sync;

   // Busy resets to 1 so the channel cannot leave RX_ANA before a real sample arrives
   always_ff @(posedge mgmt_clk) begin
      if (mgmt_reset) begin
         busy_sync_reg <= 2'b11;
         ltd_sync_reg  <= 2'b00;
      end else begin
         busy_sync_reg <= {busy_sync_reg[0], rx_cal_busy};
         ltd_sync_reg  <= {ltd_sync_reg[0], rx_is_lockedtodata};
      end
   end

   assign busy_sync = busy_sync_reg[1];
   assign ltd_sync  = ltd_sync_reg[1];

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         RX_ANA: begin
            if (cnt_reg == ANA_LAST) begin
               if (!busy_sync) begin
                  state_next = RX_LTD;
                  cnt_next   = '0;
               end
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         RX_LTD: begin
            if (!ltd_sync) begin
               cnt_next = '0;
            end else if (cnt_reg == LTD_LAST) begin
               state_next = RX_READY;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         RX_READY: begin
`ifdef GX_RST_RX_AUTORECOVER_EN
            if (!ltd_sync) begin
               state_next = RX_ANA;
               cnt_next   = '0;
            end
`endif
         end
         default: begin
            state_next = RX_ANA;
            cnt_next   = '0;
         end
      endcase
      if (rx_reset_req) begin
         state_next = RX_ANA;
         cnt_next   = '0;
      end
   end

   // Without auto-recovery, ready simply tracks lockedtodata while parked in RX_READY
   always_ff @(posedge mgmt_clk) begin
      if (mgmt_reset) begin
         state_reg   <= RX_ANA;
         cnt_reg     <= '0;
         ana_rst_reg <= 1'b1;
         dig_rst_reg <= 1'b1;
         ready_reg   <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         ana_rst_reg <= (state_next == RX_ANA);
         dig_rst_reg <= (state_next != RX_READY);
         ready_reg   <= (state_next == RX_READY) && ltd_sync;
      end
   end

   assign rx_analogreset  = ana_rst_reg;
   assign rx_digitalreset = dig_rst_reg;
   assign rx_ready        = ready_reg;

endmodule

// File: rtl/gx_std_x4_rst_ctrl.sv
// Reset sequencer for the 4-channel GX standard-PCS bank: shared bonded TX FSM plus per-channel RX FSMs.
// GX_RST_RX_AUTORECOVER_EN (in gx_std_x4_rst_rx_ch) selects RX auto-recovery on lockedtodata loss.
module gx_std_x4_rst_ctrl
   import gx_std_x4_rst_pkg::*;
#(
   parameter int NUM_CH      = DEF_NUM_CH,
   parameter int T_PLLPD_CYC = DEF_T_PLLPD_CYC,
   parameter int T_ANA_CYC   = DEF_T_ANA_CYC,
   parameter int T_LTD_CYC   = DEF_T_LTD_CYC,
   parameter int T_DIG_CYC   = DEF_T_DIG_CYC
)(
   input  logic              mgmt_clk,
   input  logic              mgmt_reset,
   input  logic              tx_reset_req,
   input  logic [NUM_CH-1:0] rx_reset_req,
   input  logic              tx_pll_locked,
   input  logic [NUM_CH-1:0] tx_cal_busy,
   input  logic [NUM_CH-1:0] rx_cal_busy,
   input  logic [NUM_CH-1:0] rx_is_lockedtodata,
   output logic              pll_powerdown,
   output logic [NUM_CH-1:0] tx_analogreset,
   output logic [NUM_CH-1:0] tx_digitalreset,
   output logic [NUM_CH-1:0] rx_analogreset,
   output logic [NUM_CH-1:0] rx_digitalreset,
   output logic [NUM_CH-1:0] tx_ready,
   output logic [NUM_CH-1:0] rx_ready
);

   localparam int CNT_MAX = max_int(T_PLLPD_CYC, max_int(T_ANA_CYC, T_DIG_CYC));
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] PD_LAST  = CNT_W'(T_PLLPD_CYC - 1);
   localparam logic [CNT_W-1:0] ANA_LAST = CNT_W'(T_ANA_CYC - 1);
   localparam logic [CNT_W-1:0] DIG_LAST = CNT_W'(T_DIG_CYC - 1);

   tx_state_t         state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [1:0]        lock_sync_reg;
   logic [NUM_CH-1:0] busy_meta_reg, busy_sync_reg;
   logic              pll_pd_reg;
   logic [NUM_CH-1:0] ana_rst_reg, dig_rst_reg, ready_reg;
   logic              locked, busy_any;

   always_ff @(posedge mgmt_clk) begin
      if (mgmt_reset) begin
         lock_sync_reg <= 2'b00;
         busy_meta_reg <= '1;
         busy_sync_reg <= '1;
      end else begin
         lock_sync_reg <= {lock_sync_reg[0], tx_pll_locked};
         busy_meta_reg <= tx_cal_busy;
         busy_sync_reg <= busy_meta_reg;
      end
   end

   assign locked   = lock_sync_reg[1];
   assign busy_any = |busy_sync_reg;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         TX_PD: begin
            if (cnt_reg == PD_LAST) begin
               state_next = TX_ANA;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         TX_ANA: begin
            if (cnt_reg == ANA_LAST) begin
               if (!busy_any) begin
                  state_next = TX_LOCK;
                  cnt_next   = '0;
               end
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         TX_LOCK: begin
            if (locked) begin
               state_next = TX_DIG;
               cnt_next   = '0;
            end
         end
         TX_DIG: begin
            if (!locked) begin
               state_next = TX_LOCK;
               cnt_next   = '0;
            end else if (cnt_reg == DIG_LAST) begin
               state_next = TX_READY;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         TX_READY: begin
            if (!locked) begin
               state_next = TX_DIG;
               cnt_next   = '0;
            end
         end
         default: begin
            state_next = TX_PD;
            cnt_next   = '0;
         end
      endcase
      // Request overrides any lock-loss transition decided above
      if (tx_reset_req) begin
         state_next = TX_PD;
         cnt_next   = '0;
      end
   end

   always_ff @(posedge mgmt_clk) begin
      if (mgmt_reset) begin
         state_reg   <= TX_PD;
         cnt_reg     <= '0;
         pll_pd_reg  <= 1'b1;
         ana_rst_reg <= '1;
         dig_rst_reg <= '1;
         ready_reg   <= '0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         pll_pd_reg  <= (state_next == TX_PD);
         ana_rst_reg <= {NUM_CH{(state_next == TX_PD) || (state_next == TX_ANA)}};
         dig_rst_reg <= {NUM_CH{state_next != TX_READY}};
         ready_reg   <= {NUM_CH{state_next == TX_READY}};
      end
   end

   assign pll_powerdown   = pll_pd_reg;
   assign tx_analogreset  = ana_rst_reg;
   assign tx_digitalreset = dig_rst_reg;
   assign tx_ready        = ready_reg;

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_rx
         gx_std_x4_rst_rx_ch #(
            .T_ANA_CYC (T_ANA_CYC),
            .T_LTD_CYC (T_LTD_CYC)
         ) u_rx_ch (
            .mgmt_clk           (mgmt_clk),
            .mgmt_reset         (mgmt_reset),
            .rx_reset_req       (rx_reset_req[gi]),
            .rx_cal_busy        (rx_cal_busy[gi]),
            .rx_is_lockedtodata (rx_is_lockedtodata[gi]),
            .rx_analogreset     (rx_analogreset[gi]),
            .rx_digitalreset    (rx_digitalreset[gi]),
            .rx_ready           (rx_ready[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_gx_std_x4_rst_ctrl.sv
// Scoreboard bench for gx_std_x4_rst_ctrl with short timing; expectations keyed to the edge index after reset release.
// Build with or without GX_RST_RX_AUTORECOVER_EN; the final scenario adapts its expectations.
`timescale 1ns/1ps
module tb_gx_std_x4_rst_ctrl;

   localparam int NUM_CH = 4;

   logic              mgmt_clk = 1'b0;
   logic              mgmt_reset = 1'b1;
   logic              tx_reset_req = 1'b0;
   logic [NUM_CH-1:0] rx_reset_req = '0;
   logic              tx_pll_locked = 1'b0;
   logic [NUM_CH-1:0] tx_cal_busy = '0;
   logic [NUM_CH-1:0] rx_cal_busy = '0;
   logic [NUM_CH-1:0] rx_is_lockedtodata = '0;
   logic              pll_powerdown;
   logic [NUM_CH-1:0] tx_analogreset, tx_digitalreset, rx_analogreset, rx_digitalreset;
   logic [NUM_CH-1:0] tx_ready, rx_ready;

   gx_std_x4_rst_ctrl #(
      .NUM_CH      (NUM_CH),
      .T_PLLPD_CYC (4),
      .T_ANA_CYC   (4),
      .T_LTD_CYC   (16),
      .T_DIG_CYC   (4)
   ) dut (
      .mgmt_clk           (mgmt_clk),
      .mgmt_reset         (mgmt_reset),
      .tx_reset_req       (tx_reset_req),
      .rx_reset_req       (rx_reset_req),
      .tx_pll_locked      (tx_pll_locked),
      .tx_cal_busy        (tx_cal_busy),
      .rx_cal_busy        (rx_cal_busy),
      .rx_is_lockedtodata (rx_is_lockedtodata),
      .pll_powerdown      (pll_powerdown),
      .tx_analogreset     (tx_analogreset),
      .tx_digitalreset    (tx_digitalreset),
      .rx_analogreset     (rx_analogreset),
      .rx_digitalreset    (rx_digitalreset),
      .tx_ready           (tx_ready),
      .rx_ready           (rx_ready)
   );

   always #5 mgmt_clk = ~mgmt_clk;

   int cyc = 0;
   always @(posedge mgmt_clk) cyc <= cyc + 1;

   // Signal selectors for scoreboard entries
   localparam int S_PLLPD = 0, S_TXANA = 1, S_TXDIG = 2, S_RXANA = 3, S_RXDIG = 4, S_TXRDY = 5, S_RXRDY = 6;

   typedef struct {
      int         cyc;
      int         sig;
      logic [3:0] val;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   base = 0;

   function automatic logic [3:0] observe(input int sig);
      case (sig)
         S_PLLPD: return {3'b000, pll_powerdown};
         S_TXANA: return tx_analogreset;
         S_TXDIG: return tx_digitalreset;
         S_RXANA: return rx_analogreset;
         S_RXDIG: return rx_digitalreset;
         S_TXRDY: return tx_ready;
         default: return rx_ready;
      endcase
   endfunction

   function automatic string sig_name(input int sig);
      case (sig)
         S_PLLPD: return "pll_powerdown";
         S_TXANA: return "tx_analogreset";
         S_TXDIG: return "tx_digitalreset";
         S_RXANA: return "rx_analogreset";
         S_RXDIG: return "rx_digitalreset";
         S_TXRDY: return "tx_ready";
         default: return "rx_ready";
      endcase
   endfunction

   // Sorted insert so each scenario can list expectations in any order
   task automatic push(input int c, input int s, input logic [3:0] v);
      int   i;
      exp_t e;
      e = '{c, s, v};
      i = 0;
      while (i < sb.size() && sb[i].cyc <= c) i++;
      sb.insert(i, e);
   endtask

   task automatic set_inputs(input logic locked, input logic [3:0] rx_busy, input logic [3:0] ltd);
      tx_reset_req       = 1'b0;
      rx_reset_req       = '0;
      tx_pll_locked      = locked;
      tx_cal_busy        = '0;
      rx_cal_busy        = rx_busy;
      rx_is_lockedtodata = ltd;
   endtask

   // Edge 0 is the last edge with reset high; base makes later edges 1, 2, ...
   task automatic do_reset();
      mgmt_reset = 1'b1;
      repeat (3) @(negedge mgmt_clk);
      mgmt_reset = 1'b0;
      base = cyc;
   endtask

   task automatic test_reset();
      set_inputs(1'b1, 4'h0, 4'hF);
      mgmt_reset = 1'b1;
      repeat (2) @(negedge mgmt_clk);
      checks++;
      if (pll_powerdown !== 1'b1) begin failures++; $display("FAIL reset pll_powerdown got %b want 1", pll_powerdown); end
      checks++;
      if (tx_analogreset !== 4'hF) begin failures++; $display("FAIL reset tx_analogreset got %h want f", tx_analogreset); end
      checks++;
      if (tx_digitalreset !== 4'hF) begin failures++; $display("FAIL reset tx_digitalreset got %h want f", tx_digitalreset); end
      checks++;
      if (rx_analogreset !== 4'hF) begin failures++; $display("FAIL reset rx_analogreset got %h want f", rx_analogreset); end
      checks++;
      if (rx_digitalreset !== 4'hF) begin failures++; $display("FAIL reset rx_digitalreset got %h want f", rx_digitalreset); end
      checks++;
      if (tx_ready !== 4'h0) begin failures++; $display("FAIL reset tx_ready got %h want 0", tx_ready); end
      checks++;
      if (rx_ready !== 4'h0) begin failures++; $display("FAIL reset rx_ready got %h want 0", rx_ready); end
      $display("reset: outputs checked while mgmt_reset held");
   endtask

   task automatic test_powerup();
      int   rel;
      exp_t e;
      set_inputs(1'b0, 4'h0, 4'h0);
      do_reset();
      push(3, S_PLLPD, 4'h1);  push(4, S_PLLPD, 4'h0);
      push(7, S_TXANA, 4'hF);  push(8, S_TXANA, 4'h0);
      push(3, S_RXANA, 4'hF);  push(4, S_RXANA, 4'h0);
      push(25, S_TXDIG, 4'hF); push(25, S_TXRDY, 4'h0);
      push(26, S_TXDIG, 4'h0); push(26, S_TXRDY, 4'hF);
      push(26, S_RXRDY, 4'h0);
      for (int n = 0; n < 30; n++) begin
         @(negedge mgmt_clk);
         rel = cyc - base;
         while (sb.size() > 0 && sb[0].cyc <= rel) begin
            e = sb.pop_front();
            checks++;
            if (observe(e.sig) !== e.val) begin
               failures++;
               $display("FAIL powerup %s @%0d got %h want %h", sig_name(e.sig), e.cyc, observe(e.sig), e.val);
            end else $display("powerup %s @%0d = %h", sig_name(e.sig), e.cyc, e.val);
         end
         if (rel == 19) tx_pll_locked = 1'b1;
      end
      checks++;
      if (sb.size() != 0) begin failures++; $display("FAIL powerup timeout got %0d pending want 0", sb.size()); sb.delete(); end
   endtask

   task automatic test_cal_extend();
      int   rel;
      exp_t e;
      set_inputs(1'b0, 4'b0010, 4'h0);
      do_reset();
      push(3, S_RXANA, 4'hF);
      push(4, S_RXANA, 4'b0010);
      push(31, S_RXANA, 4'b0010);
      push(32, S_RXANA, 4'h0);
      for (int n = 0; n < 35; n++) begin
         @(negedge mgmt_clk);
         rel = cyc - base;
         while (sb.size() > 0 && sb[0].cyc <= rel) begin
            e = sb.pop_front();
            checks++;
            if (observe(e.sig) !== e.val) begin
               failures++;
               $display("FAIL cal_extend %s @%0d got %h want %h", sig_name(e.sig), e.cyc, observe(e.sig), e.val);
            end else $display("cal_extend %s @%0d = %h", sig_name(e.sig), e.cyc, e.val);
         end
         if (rel == 29) rx_cal_busy = 4'h0;
      end
      checks++;
      if (sb.size() != 0) begin failures++; $display("FAIL cal_extend timeout got %0d pending want 0", sb.size()); sb.delete(); end
   endtask

   task automatic test_ltd_glitch();
      int   rel;
      exp_t e;
      set_inputs(1'b0, 4'h0, 4'hF);
      do_reset();
      push(19, S_RXRDY, 4'h0);
      push(20, S_RXRDY, 4'b1011);
      push(30, S_RXRDY, 4'b1011);
      push(30, S_RXDIG, 4'b0100);
      push(31, S_RXRDY, 4'hF);
      push(31, S_RXDIG, 4'h0);
      for (int n = 0; n < 35; n++) begin
         @(negedge mgmt_clk);
         rel = cyc - base;
         while (sb.size() > 0 && sb[0].cyc <= rel) begin
            e = sb.pop_front();
            checks++;
            if (observe(e.sig) !== e.val) begin
               failures++;
               $display("FAIL ltd_glitch %s @%0d got %h want %h", sig_name(e.sig), e.cyc, observe(e.sig), e.val);
            end else $display("ltd_glitch %s @%0d = %h", sig_name(e.sig), e.cyc, e.val);
         end
         if (rel == 12) rx_is_lockedtodata[2] = 1'b0;
         if (rel == 13) rx_is_lockedtodata[2] = 1'b1;
      end
      checks++;
      if (sb.size() != 0) begin failures++; $display("FAIL ltd_glitch timeout got %0d pending want 0", sb.size()); sb.delete(); end
   endtask

   task automatic test_pll_loss();
      int   rel;
      exp_t e;
      set_inputs(1'b1, 4'h0, 4'hF);
      do_reset();
      push(12, S_TXRDY, 4'h0); push(13, S_TXRDY, 4'hF); push(13, S_TXDIG, 4'h0);
      push(21, S_TXRDY, 4'hF);
      push(22, S_TXRDY, 4'h0); push(22, S_TXDIG, 4'hF);
      push(24, S_TXANA, 4'h0);
      push(28, S_TXRDY, 4'h0);
      push(29, S_TXRDY, 4'hF); push(29, S_TXDIG, 4'h0);
      // Request and synced lock loss land on edge 33 together
      push(32, S_TXRDY, 4'hF);
      push(33, S_PLLPD, 4'h1); push(33, S_TXRDY, 4'h0);
      push(38, S_PLLPD, 4'h1); push(38, S_TXANA, 4'hF);
      push(39, S_PLLPD, 4'h0);
      for (int n = 0; n < 42; n++) begin
         @(negedge mgmt_clk);
         rel = cyc - base;
         while (sb.size() > 0 && sb[0].cyc <= rel) begin
            e = sb.pop_front();
            checks++;
            if (observe(e.sig) !== e.val) begin
               failures++;
               $display("FAIL pll_loss %s @%0d got %h want %h", sig_name(e.sig), e.cyc, observe(e.sig), e.val);
            end else $display("pll_loss %s @%0d = %h", sig_name(e.sig), e.cyc, e.val);
         end
         if (rel == 19) tx_pll_locked = 1'b0;
         if (rel == 22) tx_pll_locked = 1'b1;
         if (rel == 30) tx_pll_locked = 1'b0;
         if (rel == 32) tx_reset_req = 1'b1;
         if (rel == 35) tx_reset_req = 1'b0;
      end
      checks++;
      if (sb.size() != 0) begin failures++; $display("FAIL pll_loss timeout got %0d pending want 0", sb.size()); sb.delete(); end
   endtask

   task automatic test_rx_req();
      int   rel;
      exp_t e;
      set_inputs(1'b1, 4'h0, 4'hF);
      do_reset();
      push(20, S_RXRDY, 4'hF);
      push(25, S_RXRDY, 4'hF);
      push(26, S_RXRDY, 4'b1110); push(26, S_RXANA, 4'b0001);
      push(26, S_RXDIG, 4'b0001); push(26, S_TXRDY, 4'hF);
      push(29, S_RXANA, 4'b0001); push(30, S_RXANA, 4'h0);
      push(45, S_RXRDY, 4'b1110); push(46, S_RXRDY, 4'hF);
      for (int n = 0; n < 50; n++) begin
         @(negedge mgmt_clk);
         rel = cyc - base;
         while (sb.size() > 0 && sb[0].cyc <= rel) begin
            e = sb.pop_front();
            checks++;
            if (observe(e.sig) !== e.val) begin
               failures++;
               $display("FAIL rx_req %s @%0d got %h want %h", sig_name(e.sig), e.cyc, observe(e.sig), e.val);
            end else $display("rx_req %s @%0d = %h", sig_name(e.sig), e.cyc, e.val);
         end
         if (rel == 25) rx_reset_req = 4'b0001;
         if (rel == 26) rx_reset_req = 4'b0000;
      end
      checks++;
      if (sb.size() != 0) begin failures++; $display("FAIL rx_req timeout got %0d pending want 0", sb.size()); sb.delete(); end
   endtask

   task automatic test_reset_and_loss();
      int   rel;
      exp_t e;
      set_inputs(1'b1, 4'h0, 4'hF);
      do_reset();
      push(10, S_RXANA, 4'h0);
      push(11, S_PLLPD, 4'h1); push(11, S_TXANA, 4'hF); push(11, S_TXDIG, 4'hF);
      push(11, S_RXANA, 4'hF); push(11, S_RXDIG, 4'hF); push(11, S_TXRDY, 4'h0);
      push(11, S_RXRDY, 4'h0);
      push(20, S_RXRDY, 4'h0); push(30, S_RXRDY, 4'h0); push(31, S_RXRDY, 4'hF);
      push(41, S_RXRDY, 4'hF);
      push(42, S_RXRDY, 4'b0111);
`ifdef GX_RST_RX_AUTORECOVER_EN
      push(42, S_RXANA, 4'b1000); push(42, S_RXDIG, 4'b1000);
      push(45, S_RXANA, 4'b1000); push(46, S_RXANA, 4'h0);
      push(61, S_RXRDY, 4'b0111); push(62, S_RXRDY, 4'hF);
`else
      push(42, S_RXANA, 4'h0); push(42, S_RXDIG, 4'h0);
      push(43, S_RXRDY, 4'hF); push(50, S_RXDIG, 4'h0);
`endif
      for (int n = 0; n < 65; n++) begin
         @(negedge mgmt_clk);
         rel = cyc - base;
         while (sb.size() > 0 && sb[0].cyc <= rel) begin
            e = sb.pop_front();
            checks++;
            if (observe(e.sig) !== e.val) begin
               failures++;
               $display("FAIL reset_and_loss %s @%0d got %h want %h", sig_name(e.sig), e.cyc, observe(e.sig), e.val);
            end else $display("reset_and_loss %s @%0d = %h", sig_name(e.sig), e.cyc, e.val);
         end
         if (rel == 10) mgmt_reset = 1'b1;
         if (rel == 11) mgmt_reset = 1'b0;
         if (rel == 39) rx_is_lockedtodata[3] = 1'b0;
         if (rel == 40) rx_is_lockedtodata[3] = 1'b1;
      end
      checks++;
      if (sb.size() != 0) begin failures++; $display("FAIL reset_and_loss timeout got %0d pending want 0", sb.size()); sb.delete(); end
   endtask

   initial begin
      test_reset();
      test_powerup();
      test_cal_extend();
      test_ltd_glitch();
      test_pll_loss();
      test_rx_req();
      test_reset_and_loss();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
